// File: rtl/secuenciador_ingredientes_pkg.sv
// Shared definitions for the drink recipe sequencer: FSM states,
// ingredient and drink codes, and the factory recipe table.
package cafetera_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSA = 2'd1,
        LISTO    = 2'd2
    } estado_t;

    // Ingredient stage indices, in dispensing order.
    localparam int AGUA      = 0;
    localparam int CAFE      = 1;
    localparam int LECHE     = 2;
    localparam int CHOCOLATE = 3;
    localparam int AZUCAR    = 4;

    // Drink codes.
    localparam int EXPRESO        = 0;
    localparam int CAFE_CON_LECHE = 1;
    localparam int CAPUCCINO      = 2;
    localparam int MOCACCINO      = 3;

    localparam int N_BEBIDAS_DEF = 4;
    localparam int N_INGR_DEF    = 5;

    // Seconds per stage, rows are drinks, columns agua..azucar.
    localparam int RECETA_DEF [N_BEBIDAS_DEF][N_INGR_DEF] = '{
        '{2, 3, 0, 0, 1},
        '{2, 2, 1, 0, 1},
        '{2, 1, 2, 0, 1},
        '{1, 1, 1, 2, 1}
    };

    // Drinks or stages outside the factory table dispense nothing.
    function automatic int receta_def_seg(input int b, input int i);
        if (b >= 0 && b < N_BEBIDAS_DEF && i >= 0 && i < N_INGR_DEF)
            return RECETA_DEF[b][i];
        return 0;
    endfunction

endpackage

// File: rtl/secuenciador_ingredientes_prescaler_seg.sv
// Seconds prescaler: one-cycle tick after every CICLOS_SEG enabled cycles.
// clr restarts the count at 0 so each stage begins on a full second.
module prescaler_seg #(
    parameter int CICLOS_SEG = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = (CICLOS_SEG > 1) ? $clog2(CICLOS_SEG) : 1;
    localparam logic [PW-1:0] ULTIMO = PW'(CICLOS_SEG - 1);

    logic [PW-1:0] cuenta_q, cuenta_d;

    assign tick = en && (cuenta_q == ULTIMO);

    // Next count: clear has priority, wrap on tick, otherwise advance when enabled.
    always_comb begin
        cuenta_d = cuenta_q;
        if (clr || tick) begin
            cuenta_d = '0;
        end else if (en) begin
            cuenta_d = cuenta_q + PW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

endmodule

// File: rtl/secuenciador_ingredientes.sv
// Self-timed recipe sequencer for the drink dispenser.
// Optional macro RECETA_PROG_EN: recipe becomes a writable register array
// (write port wr_*); otherwise the recipe is the package constant ROM.
//
// state    | meaning
// IDLE     | waiting for inicio, all outputs low
// DISPENSA | stepping through ingredient stages, one valve per stage
// LISTO    | drink ready, holding listo for T_LISTO seconds
module secuenciador_ingredientes
    import cafetera_pkg::*;
#(
    parameter int N_BEBIDAS  = 4,
    parameter int N_INGR     = 5,
    parameter int SEG_W      = 2,
    parameter int CICLOS_SEG = 50_000_000,
    parameter int T_LISTO    = 2,
    localparam int BW = (N_BEBIDAS > 1) ? $clog2(N_BEBIDAS) : 1,
    localparam int IW = (N_INGR > 1) ? $clog2(N_INGR) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inicio,
    input  logic              cancelar,
    input  logic [BW-1:0]     bebida,
`ifdef RECETA_PROG_EN
    input  logic              wr_en,
    input  logic [BW-1:0]     wr_bebida,
    input  logic [IW-1:0]     wr_ingr,
    input  logic [SEG_W-1:0]  wr_seg,
`endif
    output logic              ocupado,
    output logic              listo,
    output logic              error,
    output logic [N_INGR-1:0] valvula,
    output logic [IW-1:0]     ingrediente,
    output logic [SEG_W-1:0]  seg_restantes
);

    // The seconds counter also times the ready phase, so it must hold both ranges.
    localparam int LW = $clog2(T_LISTO + 1);
    localparam int CW = (SEG_W > LW) ? SEG_W : LW;

    estado_t          estado_q, estado_d;
    logic [BW-1:0]    bebida_q, bebida_d;
    logic [IW-1:0]    ingr_q, ingr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             error_q, error_d;
    logic             presc_clr, presc_en, tick;
    logic             fin_etapa, ultima;
    logic [SEG_W-1:0] seg_ini, seg_sig;
    logic [SEG_W-1:0] receta_w [N_BEBIDAS][N_INGR];

`ifdef RECETA_PROG_EN
    logic [SEG_W-1:0] receta_q [N_BEBIDAS][N_INGR];

    // Recipe registers: factory values on reset, writes accepted only while idle.
    always_ff @(posedge clk) begin
        for (int b = 0; b < N_BEBIDAS; b++) begin
            for (int i = 0; i < N_INGR; i++) begin
                if (rst) begin
                    receta_q[b][i] <= SEG_W'(receta_def_seg(b, i));
                end else if (wr_en && estado_q == IDLE &&
                             int'(wr_bebida) == b && int'(wr_ingr) == i) begin
                    receta_q[b][i] <= wr_seg;
                end
            end
        end
    end

    assign receta_w = receta_q;
`else
    for (genvar b = 0; b < N_BEBIDAS; b++) begin : g_rom_b
        for (genvar i = 0; i < N_INGR; i++) begin : g_rom_i
            assign receta_w[b][i] = SEG_W'(receta_def_seg(b, i));
        end
    end
`endif

    // Recipe lookups: first stage of the incoming drink, next stage of the latched one.
    always_comb begin
        seg_ini = '0;
        seg_sig = '0;
        for (int b = 0; b < N_BEBIDAS; b++) begin
            if (int'(bebida) == b) seg_ini = receta_w[b][0];
            for (int i = 1; i < N_INGR; i++) begin
                if (int'(bebida_q) == b && int'(ingr_q) + 1 == i) seg_sig = receta_w[b][i];
            end
        end
    end

    prescaler_seg #(
        .CICLOS_SEG (CICLOS_SEG)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (tick)
    );

    // Next-state logic: stage sequencing, seconds countdown, start/abort handling.
    always_comb begin
        estado_d  = estado_q;
        bebida_d  = bebida_q;
        ingr_d    = ingr_q;
        cnt_d     = cnt_q;
        error_d   = 1'b0;
        presc_clr = 1'b0;
        presc_en  = 1'b0;
        fin_etapa = 1'b0;
        ultima    = (int'(ingr_q) == N_INGR - 1);

        case (estado_q)
            IDLE: begin
                presc_clr = 1'b1;
                if (inicio && !cancelar) begin
                    if (int'(bebida) < N_BEBIDAS) begin
                        estado_d = DISPENSA;
                        bebida_d = bebida;
                        ingr_d   = '0;
                        cnt_d    = CW'(seg_ini);
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            DISPENSA: begin
                // A zero-second stage still occupies one cycle with the valves closed.
                if (cnt_q == '0) begin
                    fin_etapa = 1'b1;
                end else begin
                    presc_en = 1'b1;
                    if (tick) begin
                        if (cnt_q == CW'(1)) fin_etapa = 1'b1;
                        else                 cnt_d = cnt_q - CW'(1);
                    end
                end
                if (fin_etapa) begin
                    presc_clr = 1'b1;
                    if (ultima) begin
                        estado_d = LISTO;
                        ingr_d   = '0;
                        cnt_d    = CW'(T_LISTO);
                    end else begin
                        ingr_d = ingr_q + IW'(1);
                        cnt_d  = CW'(seg_sig);
                    end
                end
            end
            LISTO: begin
                presc_en = 1'b1;
                if (tick) begin
                    if (cnt_q == CW'(1)) begin
                        estado_d = IDLE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: begin
                estado_d = IDLE;
                ingr_d   = '0;
                cnt_d    = '0;
            end
        endcase

        if (cancelar && estado_q != IDLE) begin
            estado_d  = IDLE;
            ingr_d    = '0;
            cnt_d     = '0;
            presc_clr = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= IDLE;
            bebida_q <= '0;
            ingr_q   <= '0;
            cnt_q    <= '0;
            error_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            bebida_q <= bebida_d;
            ingr_q   <= ingr_d;
            cnt_q    <= cnt_d;
            error_q  <= error_d;
        end
    end

    // Valve decode: only the current stage, and only if it has a non-zero time left.
    always_comb begin
        valvula = '0;
        for (int i = 0; i < N_INGR; i++) begin
            if (estado_q == DISPENSA && cnt_q != '0 && int'(ingr_q) == i) valvula[i] = 1'b1;
        end
    end

    assign ocupado       = (estado_q != IDLE);
    assign listo         = (estado_q == LISTO);
    assign error         = error_q;
    assign ingrediente   = ingr_q;
    assign seg_restantes = (estado_q == DISPENSA) ? cnt_q[SEG_W-1:0] : '0;

endmodule
